sprite_plotter: RTL and testbench
=================================

# sprite_plotter

Pixel-drawing engine at the responding end of the movement controller's draw handshake. It accepts a one-cycle `drawBG` or `drawChar` request with an anchor coordinate and colour. It then scans a W×H sprite box one pixel per clock into the VGA adapter's plot port, and returns a one-cycle `doneBG` or `doneChar` when the box is finished. Background requests fill the whole box; character requests plot only pixels whose sprite-mask bit is set.

## Interface
Parameters:
- `SPRITE_W`, 4: box width in pixels (1–16)
- `SPRITE_H`, 4: box height in pixels (1–16)
- `SPRITE_MASK`, 16'h6FF6: W*H-bit character mask; bit index = row*SPRITE_W + col, 1 = plot
- `SCREEN_W`, 240: visible columns
- `SCREEN_H`, 120: visible rows

Ports:
- `clock` in 1: single system clock, rising edge
- `resetn` in 1: reset, asynchronous and active-low
- `drawBG` in 1: one-cycle request to fill the box (erase)
- `drawChar` in 1: one-cycle request to draw the masked sprite
- `xIn` in 8: anchor column (top-left of the box)
- `yIn` in 7: anchor row (top-left of the box)
- `colorIn` in 3: colour for this request
- `x` out 8: pixel column to the VGA adapter
- `y` out 7: pixel row to the VGA adapter
- `colour` out 3: pixel colour
- `plot` out 1: write strobe for the current pixel
- `busy` out 1: high from the accepted request through the done pulse
- `doneBG` out 1: one-cycle completion pulse for a drawBG request
- `doneChar` out 1: one-cycle completion pulse for a drawChar request

## Operation
- The FSM has three states: IDLE, SCAN, DONE.
- **IDLE**
  - `busy`=0.
  - On `drawBG` or `drawChar`: latch `xIn`, `yIn`, `colorIn` and the mode, clear col/row, go to SCAN.
  - If both requests are high in the same cycle, BG wins; the char request is dropped.
- **SCAN**
  - One pixel per cycle, raster order, column fastest.
  - Pixel column = base x + col, computed 9 bits wide; pixel row = base y + row, computed 8 bits wide.
  - `x`/`y` carry the low 8/7 bits of those sums.
  - `plot`=1 only when both conditions hold:
    - the pixel is on screen: sum x < SCREEN_W and sum y < SCREEN_H;
    - mode is BG, or `SPRITE_MASK[row*SPRITE_W+col]`=1.
  - Off-screen or masked pixels still take their cycle, with `plot`=0.
  - After col=SPRITE_W-1 and row=SPRITE_H-1, go to DONE.
- **DONE**
  - Pulse `doneBG` or `doneChar` according to the latched mode, for exactly one cycle.
  - Return to IDLE.
- Requests arriving while `busy`=1 (SCAN or DONE) are ignored. There is no queueing.
- `colour` = latched `colorIn` during SCAN; it holds its last value otherwise.

## Timing
- Reset values: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `doneBG`=0, `doneChar`=0. Counters are 0; state is IDLE.
- All outputs are registered.
- Request sampled at edge N:
  - first pixel (col 0, row 0) is valid during cycle N+1;
  - last pixel is valid during cycle N+W*H;
  - done pulse is high during cycle N+W*H+1.
- `busy` rises in cycle N+1 and falls in cycle N+W*H+2.
- A new request is accepted no earlier than the edge ending cycle N+W*H+1. The requester's one-cycle gap after done satisfies this.
- Reset asserted mid-scan: all outputs clear immediately (asynchronously). No done pulse is produced for the aborted request.
- `plot` is never high outside SCAN.

## Structure
- Shared package `sprite_pkg` holds:
  - FSM state encoding (IDLE, SCAN, DONE);
  - mode constants `MODE_BG`=0 and `MODE_CHAR`=1;
  - default SCREEN_W/SCREEN_H;
  - colour constants `COL_BLACK`=3'b000 and `COL_RED`=3'b100.
- One sub-module: `box_scan_counter`, which holds the col/row counters.
  - Inputs: clear and enable.
  - Outputs: col, row, and `last` (asserted at col=W-1, row=H-1).
- `sprite_plotter` holds the FSM, anchor/colour/mode registers, adders, clipping and mask lookup.

## Test plan
- drawBG, xIn=1, yIn=16, colorIn=0 (default 4×4):
  - 16 consecutive cycles with plot=1, covering (1..4, 16..19) in raster order, colour 0;
  - doneBG one cycle later; doneChar stays 0.
- drawChar, xIn=10, yIn=20, colorIn=3'b100, mask 16'h6FF6:
  - plot=1 exactly at the 12 set-bit pixels; the corners (10,20), (13,20), (10,23), (13,23) have plot=0;
  - doneChar 17 cycles after the request.
- drawBG at xIn=238, yIn=118:
  - only (238..239, 118..119) are plotted, 4 pixels;
  - doneBG still arrives exactly 17 cycles after the request.
- drawBG and drawChar high together, then drawChar pulsed during SCAN:
  - exactly one BG fill and one doneBG; no doneChar.
- resetn pulled low at the 6th pixel of a drawChar:
  - all outputs are 0 in the same cycle; no done pulse;
  - a drawBG after release completes normally.
- Back-to-back: drawBG, then drawChar one cycle after doneBG:
  - both complete; pulses are 17 cycles apart, plus the one-cycle gap.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared FSM encoding, mode/colour constants and clipping helper
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_BG   = 1'b0;
  localparam logic MODE_CHAR = 1'b1;

  localparam int DEF_SCREEN_W = 240;
  localparam int DEF_SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;

  // Box counters cover sprites up to 16x16.
  localparam int CNT_W = 4;

  function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy,
                                     input int sw, input int sh);
    return (int'(sx) < sw) && (int'(sy) < sh);
  endfunction

endpackage

// File: rtl/box_scan_counter.sv
// rtl/box_scan_counter.sv - raster col/row counter over a W x H box, column fastest
module box_scan_counter
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last
);

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             col_end;
  logic             row_end;

  assign col_end = (col_q == CNT_W'(SPRITE_W - 1));
  assign row_end = (row_q == CNT_W'(SPRITE_H - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (enable) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_end && row_end;

endmodule

// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - scans a sprite box one pixel per clock into the VGA plot port
module sprite_plotter
  import sprite_pkg::*;
#(
  parameter int                             SPRITE_W    = 4,
  parameter int                             SPRITE_H    = 4,
  parameter logic [SPRITE_W*SPRITE_H-1:0]   SPRITE_MASK = 16'h6FF6,
  parameter int                             SCREEN_W    = DEF_SCREEN_W,
  parameter int                             SCREEN_H    = DEF_SCREEN_H
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       drawBG,
  input  logic       drawChar,
  input  logic [7:0] xIn,
  input  logic [6:0] yIn,
  input  logic [2:0] colorIn,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       doneBG,
  output logic       doneChar
);

  localparam logic [255:0] MASK_FULL = 256'(SPRITE_MASK);

  state_e     state_q, state_d;
  logic       mode_q, mode_d;
  logic [7:0] base_x_q, base_x_d;
  logic [6:0] base_y_q, base_y_d;
  logic       scan_end_q, scan_end_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_bg_q, done_bg_d;
  logic       done_char_q, done_char_d;

  logic             cnt_clr, cnt_en, cnt_last;
  logic [CNT_W-1:0] cnt_col, cnt_row;

  logic       req;
  logic [7:0] pix_bx;
  logic [6:0] pix_by;
  logic       pix_mode;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic [7:0] mask_idx;
  logic       pix_plot;

  box_scan_counter #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_cnt (
    .clock  (clock),
    .resetn (resetn),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .col    (cnt_col),
    .row    (cnt_row),
    .last   (cnt_last)
  );

  assign req = drawBG || drawChar;

  // The first pixel is emitted on the accepting edge, so IDLE uses the live inputs.
  always_comb begin
    pix_bx   = base_x_q;
    pix_by   = base_y_q;
    pix_mode = mode_q;
    if (state_q == ST_IDLE) begin
      pix_bx   = xIn;
      pix_by   = yIn;
      pix_mode = drawBG ? MODE_BG : MODE_CHAR;
    end
    sum_x    = {1'b0, pix_bx} + 9'(cnt_col);
    sum_y    = {1'b0, pix_by} + 8'(cnt_row);
    mask_idx = 8'(cnt_row) * 8'(SPRITE_W) + 8'(cnt_col);
    pix_plot = on_screen(sum_x, sum_y, SCREEN_W, SCREEN_H) &&
               ((pix_mode == MODE_BG) || MASK_FULL[mask_idx]);
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_x_d    = base_x_q;
    base_y_d    = base_y_q;
    scan_end_d  = scan_end_q;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    plot_d      = 1'b0;
    busy_d      = busy_q;
    done_bg_d   = 1'b0;
    done_char_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          state_d    = ST_SCAN;
          mode_d     = pix_mode;
          base_x_d   = xIn;
          base_y_d   = yIn;
          colour_d   = colorIn;
          x_d        = sum_x[7:0];
          y_d        = sum_y[6:0];
          plot_d     = pix_plot;
          busy_d     = 1'b1;
          cnt_en     = 1'b1;
          scan_end_d = cnt_last;
        end
      end
      ST_SCAN: begin
        if (scan_end_q) begin
          state_d     = ST_DONE;
          done_bg_d   = (mode_q == MODE_BG);
          done_char_d = (mode_q == MODE_CHAR);
          scan_end_d  = 1'b0;
          cnt_clr     = 1'b1;
        end else begin
          x_d        = sum_x[7:0];
          y_d        = sum_y[6:0];
          plot_d     = pix_plot;
          cnt_en     = 1'b1;
          scan_end_d = cnt_last;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_BG;
      base_x_q    <= '0;
      base_y_q    <= '0;
      scan_end_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= COL_BLACK;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_bg_q   <= 1'b0;
      done_char_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_x_q    <= base_x_d;
      base_y_q    <= base_y_d;
      scan_end_q  <= scan_end_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
      done_bg_q   <= done_bg_d;
      done_char_q <= done_char_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign plot     = plot_q;
  assign busy     = busy_q;
  assign doneBG   = done_bg_q;
  assign doneChar = done_char_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// tb/tb_sprite_plotter.sv - scoreboard bench for sprite_plotter with randomized requests
module tb_sprite_plotter;
  import sprite_pkg::*;

  localparam int          W    = 4;
  localparam int          H    = 4;
  localparam int          NPIX = W * H;
  localparam logic [15:0] MASK = 16'h6FF6;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       drawBG = 1'b0;
  logic       drawChar = 1'b0;
  logic [7:0] xIn = '0;
  logic [6:0] yIn = '0;
  logic [2:0] colorIn = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, doneBG, doneChar;

  sprite_plotter dut (
    .clock    (clock),
    .resetn   (resetn),
    .drawBG   (drawBG),
    .drawChar (drawChar),
    .xIn      (xIn),
    .yIn      (yIn),
    .colorIn  (colorIn),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .doneBG   (doneBG),
    .doneChar (doneChar)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  typedef struct {
    int cyc;
    bit bg;
  } done_t;

  pix_t  exp_pix[$];
  done_t exp_done[$];

  int cyc = 0;
  int tests = 0;
  int failed = 0;
  int plot_seen = 0;
  int win_s = -1;
  int win_e = -2;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: every box pixel in raster order, kept when on screen and (BG or mask bit set).
  task automatic model(input bit bg, input logic [7:0] bx, input logic [6:0] by,
                       input logic [2:0] c, input int e, output int n);
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int col = 0; col < W; col++) begin
        int sx, sy, idx;
        pix_t p;
        sx  = int'(bx) + col;
        sy  = int'(by) + r;
        idx = r * W + col;
        if (sx < 240 && sy < 120 && (bg || MASK[idx])) begin
          p.cyc = e + idx;
          p.px  = 8'(sx);
          p.py  = 7'(sy);
          p.pc  = c;
          exp_pix.push_back(p);
          n++;
        end
      end
    end
    exp_done.push_back('{e + NPIX, bg});
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      check("busy", 64'(busy), 64'(cyc >= win_s && cyc <= win_e));
      if (plot) begin
        plot_seen++;
        if (exp_pix.size() == 0) begin
          check("unexpected_plot", 64'({x, y}), 64'hFFFF);
        end else begin
          pix_t p;
          p = exp_pix.pop_front();
          check("pixel{cyc,x,y,col}", 64'({16'(cyc), x, y, colour}),
                64'({16'(p.cyc), p.px, p.py, p.pc}));
        end
      end
      if (doneBG || doneChar) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 64'({doneBG, doneChar}), 64'h0);
        end else begin
          done_t d;
          d = exp_done.pop_front();
          check("done{cyc,bg,char}", 64'({16'(cyc), doneBG, doneChar}),
                64'({16'(d.cyc), d.bg, !d.bg}));
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_outs"}, 64'({x, y, colour, plot, busy, doneBG, doneChar}), 64'h0);
  endtask

  task automatic run_req(input bit bg, input bit ch, input logic [7:0] bx, input logic [6:0] by,
                         input logic [2:0] c, input int intr, input int gap);
    int e, n, p0;
    e = cyc + 1;
    model(bg, bx, by, c, e, n);
    win_s = e;
    win_e = e + NPIX;
    p0 = plot_seen;
    drawBG = bg; drawChar = ch; xIn = bx; yIn = by; colorIn = c;
    @(posedge clock); #1;
    drawBG = 0; drawChar = 0;
    for (int t = 1; t <= NPIX + gap; t++) begin
      if (t == intr) begin
        drawBG = 1'($urandom); drawChar = 1'b1;
        xIn = 8'($urandom); yIn = 7'($urandom); colorIn = 3'($urandom);
      end
      @(posedge clock); #1;
      drawBG = 0; drawChar = 0;
    end
    check("plot_count", 64'(plot_seen - p0), 64'(n));
    check("queues_drained", 64'(exp_pix.size() + exp_done.size()), 64'h0);
  endtask

  task automatic reset_mid_scan(input logic [7:0] bx, input logic [6:0] by);
    int e, n;
    e = cyc + 1;
    model(1'b0, bx, by, COL_RED, e, n);
    win_s = e;
    win_e = e + NPIX;
    drawChar = 1; xIn = bx; yIn = by; colorIn = COL_RED;
    @(posedge clock); #1;
    drawChar = 0;
    repeat (5) @(posedge clock);
    #1;
    resetn = 0;
    #1;
    check_zero("midscan_reset");
    exp_pix.delete();
    exp_done.delete();
    win_e = cyc - 1;
    repeat (2) @(posedge clock);
    #2;
    check_zero("held_reset");
    resetn = 1;
    repeat (NPIX + 2) @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    resetn = 1;
    @(posedge clock); #1;

    run_req(1, 0, 8'd1, 7'd16, COL_BLACK, 0, 2);
    run_req(0, 1, 8'd10, 7'd20, COL_RED, 0, 2);
    run_req(1, 0, 8'd238, 7'd118, 3'd5, 0, 2);
    run_req(1, 1, 8'd50, 7'd50, 3'd3, 5, 2);
    reset_mid_scan(8'd30, 7'd40);
    run_req(1, 0, 8'd100, 7'd60, 3'd2, 0, 1);
    run_req(0, 1, 8'd101, 7'd61, 3'd6, 0, 2);

    for (int i = 0; i < 24; i++) begin
      bit bg, ch;
      bg = 1'($urandom);
      ch = bg ? 1'($urandom) : 1'b1;
      run_req(bg, ch, 8'($urandom), 7'($urandom), 3'($urandom),
              $urandom_range(0, NPIX + 1), $urandom_range(1, 3));
    end

    check("final_pix_queue", 64'(exp_pix.size()), 64'h0);
    check("final_done_queue", 64'(exp_done.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
